// File: rtl/fadd_issue_collector_if.sv
// rtl/fadd_issue_collector_if.sv - request, adder-side and result signals of the float-add issue collector
interface fadd_issue_collector_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             in_sub;
   logic [1:0]       in_rm;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      fa_a;
   logic [31:0]      fa_b;
   logic             fa_sub;
   logic [1:0]       fa_rm;
   logic             fa_e;
   logic [31:0]      fa_s;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_s;
   logic [TAG_W-1:0] out_tag;
   logic [3:0]       out_flags;
   logic             busy;

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_rm, in_tag, fa_s, out_ready,
      output in_ready, fa_a, fa_b, fa_sub, fa_rm, fa_e, out_valid, out_s, out_tag, out_flags, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, in_rm, in_tag, fa_s, out_ready,
      input  in_ready, fa_a, fa_b, fa_sub, fa_rm, fa_e, out_valid, out_s, out_tag, out_flags, busy
   );
endinterface

// File: rtl/fadd_issue_collector.sv
// rtl/fadd_issue_collector.sv - issue, in-flight tracking and ordered result FIFO around a fixed-latency float adder
module fadd_issue_collector #(
   parameter int LAT   = 3,
   parameter int DEPTH = 8,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   clr,
   fadd_issue_collector_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + LAT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

   logic [LAT-1:0]   r_trk_v;
   logic [TAG_W-1:0] r_trk_tag [LAT];

   logic [31:0]      r_mem_s     [DEPTH];
   logic [TAG_W-1:0] r_mem_tag   [DEPTH];
   logic [3:0]       r_mem_flags [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;

   logic [CW-1:0]    w_inflight;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;
   logic [3:0]       w_flags;

   function automatic logic [3:0] flags_of(input logic [31:0] s);
      logic e_ff;
      logic e_0;
      logic f_0;
      e_ff = &s[30:23];
      e_0  = ~|s[30:23];
      f_0  = ~|s[22:0];
      return {e_ff & ~f_0, e_ff & f_0, e_0 & f_0, e_0 & ~f_0};
   endfunction

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + CW'(r_trk_v[i]);
      end
   end

   // Credits count both in-flight ops and queued results, so every accepted op owns a FIFO slot.
   assign bus.in_ready = ~clr & ((w_inflight + r_count) < DEPTH_C);
   assign w_accept     = bus.in_valid & bus.in_ready;

   assign bus.fa_a   = w_accept ? bus.in_a   : 32'h0;
   assign bus.fa_b   = w_accept ? bus.in_b   : 32'h0;
   assign bus.fa_sub = w_accept ? bus.in_sub : 1'b0;
   assign bus.fa_rm  = w_accept ? bus.in_rm  : 2'b00;
   assign bus.fa_e   = ~clr;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_trk_v <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_trk_tag[i] <= '0;
         end
      end else begin
         r_trk_v[0]   <= w_accept;
         r_trk_tag[0] <= bus.in_tag;
         for (int i = 1; i < LAT; i++) begin
            r_trk_v[i]   <= r_trk_v[i-1];
            r_trk_tag[i] <= r_trk_tag[i-1];
         end
      end
   end

   assign w_push      = r_trk_v[LAT-1];
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid & bus.out_ready;
   assign w_flags     = flags_of(bus.fa_s);

   // Storage is not reset; outputs are masked while empty instead.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_s[r_wr]     <= bus.fa_s;
         r_mem_tag[r_wr]   <= r_trk_tag[LAT-1];
         r_mem_flags[r_wr] <= w_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= (r_wr == LAST_P) ? '0 : r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= (r_rd == LAST_P) ? '0 : r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign bus.out_valid = w_out_valid;
   assign bus.out_s     = w_out_valid ? r_mem_s[r_rd]     : 32'h0;
   assign bus.out_tag   = w_out_valid ? r_mem_tag[r_rd]   : '0;
   assign bus.out_flags = w_out_valid ? r_mem_flags[r_rd] : 4'h0;
   assign bus.busy      = (w_inflight != '0) | w_out_valid;
endmodule

// File: tb/tb_fadd_issue_collector.sv
// tb/tb_fadd_issue_collector.sv - directed bench for fadd_issue_collector with a table-driven adder stand-in
module tb_fadd_issue_collector;
   localparam int LAT   = 3;
   localparam int DEPTH = 8;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   fadd_issue_collector_if #(.TAG_W(TAG_W)) bus_if ();

   fadd_issue_collector #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Stand-in adder: known vectors from a table, x+0 returns x.
   function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
      if (a == 32'h3f800000 && b == 32'h3f800000 && !sub) return 32'h40000000;
      if (a == 32'h3f800000 && b == 32'h3f800000 &&  sub) return 32'h00000000;
      if (a == 32'h7f800000 && b == 32'h7f800000 &&  sub) return 32'h7fc00000;
      if (a == 32'h7f7fffff && b == 32'h7f7fffff && !sub) return 32'h7f800000;
      if (a == 32'h00000007 && b == 32'h00000008 && !sub) return 32'h0000000f;
      if (b == 32'h0) return a;
      return a ^ b;
   endfunction

   logic        adder_clr_n;
   logic [31:0] r_pipe [LAT];
   assign adder_clr_n = ~clr;

   always_ff @(posedge clk) begin
      if (!adder_clr_n) begin
         for (int i = 0; i < LAT; i++) r_pipe[i] <= 32'h0;
      end else if (bus_if.fa_e) begin
         r_pipe[0] <= fake_add(bus_if.fa_a, bus_if.fa_b, bus_if.fa_sub);
         for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end
   assign bus_if.fa_s = r_pipe[LAT-1];

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [1:0] rm, input logic [TAG_W-1:0] tag);
      int k;
      @(negedge clk);
      bus_if.in_a = a; bus_if.in_b = b; bus_if.in_sub = sub; bus_if.in_rm = rm; bus_if.in_tag = tag;
      bus_if.in_valid = 1'b1;
      k = 0;
      while (!bus_if.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 bus_if.in_valid = 1'b0;
   endtask

   task automatic pop(output logic [31:0] s, output logic [TAG_W-1:0] tag,
                      output logic [3:0] fl, output bit ok);
      int k;
      @(negedge clk);
      k = 0;
      while (!bus_if.out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      ok  = bus_if.out_valid;
      s   = bus_if.out_s;
      tag = bus_if.out_tag;
      fl  = bus_if.out_flags;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({bus_if.out_valid, bus_if.busy, bus_if.in_ready, bus_if.fa_e} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got {out_valid,busy,in_ready,fa_e}=%b want 0000",
                  {bus_if.out_valid, bus_if.busy, bus_if.in_ready, bus_if.fa_e});
      end
      n_tests++;
      if ({bus_if.out_s, bus_if.out_tag, bus_if.out_flags} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got s=%h tag=%h flags=%b want 0", bus_if.out_s, bus_if.out_tag, bus_if.out_flags);
      end
      clr = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus_if.in_ready, bus_if.fa_e} !== 2'b11 || bus_if.fa_a !== 32'h0) begin
         n_fail++;
         $display("FAIL post_reset: got in_ready=%b fa_e=%b fa_a=%h want 1 1 0", bus_if.in_ready, bus_if.fa_e, bus_if.fa_a);
      end
   endtask

   task automatic test_single;
      int lat;
      @(negedge clk);
      bus_if.in_a = 32'h3f800000; bus_if.in_b = 32'h3f800000; bus_if.in_sub = 1'b0;
      bus_if.in_rm = 2'd0; bus_if.in_tag = 4'd5; bus_if.in_valid = 1'b1;
      #1;
      n_tests++;
      if ({bus_if.in_ready, bus_if.fa_a, bus_if.fa_b, bus_if.fa_sub, bus_if.fa_rm} !== {1'b1, 32'h3f800000, 32'h3f800000, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL issue_passthru: got rdy=%b a=%h b=%h sub=%b rm=%h want 1 3f800000 3f800000 0 0",
                  bus_if.in_ready, bus_if.fa_a, bus_if.fa_b, bus_if.fa_sub, bus_if.fa_rm);
      end
      @(posedge clk);
      #1 bus_if.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      n_tests++;
      if (bus_if.fa_a !== 32'h0 || bus_if.fa_b !== 32'h0) begin
         n_fail++;
         $display("FAIL bubble_zero: got fa_a=%h fa_b=%h want 0 0", bus_if.fa_a, bus_if.fa_b);
      end
      while (!bus_if.out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      n_tests++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL single_latency: got %0d edges want 4", lat);
      end
      n_tests++;
      if ({bus_if.out_s, bus_if.out_tag, bus_if.out_flags, bus_if.busy} !== {32'h40000000, 4'd5, 4'b0000, 1'b1}) begin
         n_fail++;
         $display("FAIL single_result: got s=%h tag=%0d flags=%b busy=%b want 40000000 5 0000 1",
                  bus_if.out_s, bus_if.out_tag, bus_if.out_flags, bus_if.busy);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus_if.out_valid, bus_if.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_drain: got out_valid=%b busy=%b want 0 0", bus_if.out_valid, bus_if.busy);
      end
   endtask

   task automatic test_specials;
      logic [31:0]      exp_s  [4];
      logic [3:0]       exp_fl [4];
      logic [31:0]      s;
      logic [TAG_W-1:0] tag;
      logic [3:0]       fl;
      bit               ok;
      exp_s  = '{32'h00000000, 32'h7fc00000, 32'h7f800000, 32'h0000000f};
      exp_fl = '{4'b0010, 4'b1000, 4'b0100, 4'b0001};
      bus_if.out_ready = 1'b0;
      issue(32'h3f800000, 32'h3f800000, 1'b1, 2'd0, 4'd0);
      issue(32'h7f800000, 32'h7f800000, 1'b1, 2'd0, 4'd1);
      issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, 2'd0, 4'd2);
      issue(32'h00000007, 32'h00000008, 1'b0, 2'd0, 4'd3);
      for (int i = 0; i < 4; i++) begin
         pop(s, tag, fl, ok);
         n_tests++;
         if (!ok || s !== exp_s[i] || tag !== 4'(i) || fl !== exp_fl[i]) begin
            n_fail++;
            $display("FAIL special_%0d: got ok=%0d s=%h tag=%0d flags=%b want s=%h tag=%0d flags=%b",
                     i, ok, s, tag, fl, exp_s[i], i, exp_fl[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      int nacc;
      nacc = 0;
      bus_if.out_ready = 1'b0;
      bus_if.in_b = 32'h0; bus_if.in_sub = 1'b0; bus_if.in_rm = 2'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus_if.in_tag = 4'(nacc);
         bus_if.in_a = 32'h3f800000 | (32'(nacc) << 4);
         bus_if.in_valid = 1'b1;
         if (bus_if.in_ready) nacc++;
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      n_tests++;
      if (nacc !== DEPTH) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d accepts want %0d", nacc, DEPTH);
      end
      n_tests++;
      if ({bus_if.in_ready, bus_if.out_valid, bus_if.busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL bp_full: got in_ready=%b out_valid=%b busy=%b want 0 1 1",
                  bus_if.in_ready, bus_if.out_valid, bus_if.busy);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (!bus_if.out_valid || bus_if.out_tag !== 4'(i) || bus_if.out_s !== (32'h3f800000 | (32'(i) << 4))) begin
            n_fail++;
            $display("FAIL bp_drain_%0d: got v=%b tag=%0d s=%h want 1 %0d %h", i, bus_if.out_valid,
                     bus_if.out_tag, bus_if.out_s, i, 32'h3f800000 | (32'(i) << 4));
         end
         bus_if.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (i == 0) begin
            n_tests++;
            if (bus_if.in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_ready_back: got in_ready=%b want 1", bus_if.in_ready);
            end
         end
      end
      bus_if.out_ready = 1'b0;
      n_tests++;
      if ({bus_if.out_valid, bus_if.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL bp_empty: got out_valid=%b busy=%b want 0 0", bus_if.out_valid, bus_if.busy);
      end
   endtask

   task automatic test_streaming;
      int i_iss, n_rx, cyc, first_rx, drops, bubbles, order_err;
      i_iss = 0; n_rx = 0; cyc = 0; first_rx = -1; drops = 0; bubbles = 0; order_err = 0;
      bus_if.out_ready = 1'b1;
      bus_if.in_b = 32'h0; bus_if.in_sub = 1'b0; bus_if.in_rm = 2'd1;
      while (n_rx < 20 && cyc < 80) begin
         @(negedge clk);
         if (bus_if.out_valid) begin
            if (bus_if.out_tag !== 4'(n_rx) || bus_if.out_s !== (32'h40000000 | (32'(n_rx) << 8))) order_err++;
            if (first_rx < 0) first_rx = cyc;
            n_rx++;
         end else if (first_rx >= 0) begin
            bubbles++;
         end
         if (i_iss < 20) begin
            if (!bus_if.in_ready) drops++;
            bus_if.in_tag = 4'(i_iss);
            bus_if.in_a = 32'h40000000 | (32'(i_iss) << 8);
            bus_if.in_valid = 1'b1;
            if (bus_if.in_ready) i_iss++;
         end else begin
            bus_if.in_valid = 1'b0;
         end
         cyc++;
      end
      bus_if.in_valid = 1'b0;
      n_tests++;
      if (n_rx !== 20 || order_err !== 0) begin
         n_fail++;
         $display("FAIL stream_order: got rx=%0d order_errors=%0d want 20 0", n_rx, order_err);
      end
      n_tests++;
      if (drops !== 0 || bubbles !== 0) begin
         n_fail++;
         $display("FAIL stream_rate: got ready_drops=%0d bubbles=%0d want 0 0", drops, bubbles);
      end
      n_tests++;
      if (first_rx !== 4) begin
         n_fail++;
         $display("FAIL stream_fill: got first result at cycle %0d want 4", first_rx);
      end
      bus_if.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      int nres;
      logic [TAG_W-1:0] last_tag;
      logic [31:0]      last_s;
      nres = 0; last_tag = '0; last_s = '0;
      bus_if.out_ready = 1'b0;
      issue(32'h3f800000, 32'h0, 1'b0, 2'd0, 4'd1);
      issue(32'h3f900000, 32'h0, 1'b0, 2'd0, 4'd2);
      issue(32'h3fa00000, 32'h0, 1'b0, 2'd0, 4'd3);
      @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      #1;
      n_tests++;
      if ({bus_if.in_ready, bus_if.fa_e} !== 2'b00) begin
         n_fail++;
         $display("FAIL midclr_ctrl: got in_ready=%b fa_e=%b want 0 0", bus_if.in_ready, bus_if.fa_e);
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({bus_if.out_valid, bus_if.busy, bus_if.in_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL midclr_state: got out_valid=%b busy=%b in_ready=%b want 000",
                  bus_if.out_valid, bus_if.busy, bus_if.in_ready);
      end
      clr = 1'b0;
      issue(32'h3f800000, 32'h3f800000, 1'b0, 2'd0, 4'd9);
      bus_if.out_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus_if.out_valid) begin
            nres++;
            last_tag = bus_if.out_tag;
            last_s   = bus_if.out_s;
         end
      end
      bus_if.out_ready = 1'b0;
      n_tests++;
      if (nres !== 1 || last_tag !== 4'd9 || last_s !== 32'h40000000) begin
         n_fail++;
         $display("FAIL midclr_after: got results=%0d tag=%0d s=%h want 1 9 40000000", nres, last_tag, last_s);
      end
   endtask

   task automatic test_push_pop;
      bus_if.out_ready = 1'b0;
      issue(32'h3fc00000, 32'h0, 1'b0, 2'd0, 4'd10);
      issue(32'h40400000, 32'h0, 1'b0, 2'd0, 4'd11);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_tag !== 4'd10) begin
         n_fail++;
         $display("FAIL pp_head: got v=%b tag=%0d want 1 10", bus_if.out_valid, bus_if.out_tag);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_tag !== 4'd11 || bus_if.out_s !== 32'h40400000) begin
         n_fail++;
         $display("FAIL pp_swap: got v=%b tag=%0d s=%h want 1 11 40400000", bus_if.out_valid, bus_if.out_tag, bus_if.out_s);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus_if.out_valid, bus_if.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL pp_count_one: got out_valid=%b busy=%b want 0 0", bus_if.out_valid, bus_if.busy);
      end
   endtask

   initial begin
      bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0; bus_if.in_sub = 1'b0;
      bus_if.in_rm = '0; bus_if.in_tag = '0; bus_if.out_ready = 1'b0;
      test_reset;
      test_single;
      test_specials;
      test_backpressure;
      test_streaming;
      test_reset_mid;
      test_push_pop;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary want finished run");
      $fatal(1, "timeout");
   end
endmodule
